// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep checker and its optional signature MISR.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int              SIG_W     = 16;
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
    localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

    // One serial step of the x^16+x^12+x^5+1 compactor.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig, input logic din);
        logic fb;
        fb = sig[SIG_W-1] ^ din;
        misr_step = {sig[SIG_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
    endfunction

endpackage

// File: rtl/sweep_misr.sv
// Serial-input 16-bit signature register; seeded on reset and on clr, advanced on en.
module sweep_misr
    import sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= MISR_SEED;
        end else if (clr) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= misr_step(sig, din);
        end
    end

endmodule

// File: rtl/sweep_checker.sv
// Exhaustive pattern sweeper comparing a unit under test against a reference response.
// Define SWEEP_MISR_EN to add a 16-bit response signature output.
module sweep_checker
    import sweep_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DWELL = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] pattern,
    input  logic             dut_f,
    input  logic             ref_f,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   mismatch_cnt,
    output logic             fail_valid,
    output logic [WIDTH-1:0] first_fail
`ifdef SWEEP_MISR_EN
    ,
    output logic [SIG_W-1:0] signature
`endif
);

    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
    localparam logic [WIDTH-1:0] PAT_LAST   = '1;

    state_t     state;
    logic [7:0] dwell_cnt;
    logic       accept;
    logic       sample;

    assign accept = start && (state != DRIVE);
    assign sample = (state == DRIVE) && (dwell_cnt == DWELL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pattern      <= '0;
            dwell_cnt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state        <= DRIVE;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pattern      <= '0;
                        dwell_cnt    <= '0;
                        mismatch_cnt <= '0;
                        fail_valid   <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        if (dut_f != ref_f) begin
                            mismatch_cnt <= mismatch_cnt + (WIDTH+1)'(1);
                            if (!fail_valid) begin
                                first_fail <= pattern;
                                fail_valid <= 1'b1;
                            end
                        end
                        // Last pattern ends the sweep; pattern holds all-ones in DONE.
                        if (pattern == PAT_LAST) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            dwell_cnt <= '0;
                        end else begin
                            pattern   <= pattern + WIDTH'(1);
                            dwell_cnt <= '0;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SWEEP_MISR_EN
    sweep_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (sample),
        .din   (dut_f),
        .sig   (signature)
    );
`endif

endmodule
